// File: rtl/ln_lod.sv
// ln_lod: two-stage leading-one detector for the ln datapath.
// S1 finds the highest set bit inside each SEG_W-wide segment of F;
// S2 picks the highest non-empty segment and forms the bit index, the
// one-hot mask and the zero flag. Both stages share one enable so the
// pipeline behaves as a single elastic unit under backpressure.
// DATA_W must be an integer multiple of SEG_W.
module ln_lod #(
  parameter int DATA_W = 32,
  parameter int SEG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_F,
  output logic [DATA_W-1:0] out_one_hot,
  output logic [DATA_W-1:0] out_w,
  output logic              out_zero
);

  localparam int NSEG = DATA_W / SEG_W;
  localparam int LW   = (SEG_W > 1) ? $clog2(SEG_W) : 1;

  // Pipeline enable: advance whenever the output slot is empty or being drained.
  logic en;
  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  // ---------------------------------------------------------------------------
  // Stage 1: per-segment any-set flag and local index of the highest set bit
  // ---------------------------------------------------------------------------
  logic                      s1_valid_q;
  logic [DATA_W-1:0]         s1_f_q;
  logic [NSEG-1:0]           s1_any_d, s1_any_q;
  logic [NSEG-1:0][LW-1:0]   s1_loc_d, s1_loc_q;

  // Segment search: ascending bit scan so the last hit is the highest set bit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    s1_any_d = '0;
    s1_loc_d = '0;
    for (int s = 0; s < NSEG; s++) begin
      for (int b = 0; b < SEG_W; b++) begin
        if (in_data[s*SEG_W + b]) begin
          s1_any_d[s] = 1'b1;
          s1_loc_d[s] = LW'(b);
        end
      end
    end
  end

  // S1 register: capture operand and segment results when the pipeline moves.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      s1_valid_q <= 1'b0;
      // NOTE: data registers are reset as well so bubbles never carry X into later stages.
      s1_f_q     <= '0;
      s1_any_q   <= '0;
      s1_loc_q   <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_f_q     <= in_data;
      s1_any_q   <= s1_any_d;
      s1_loc_q   <= s1_loc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: select highest non-empty segment, build index / mask / zero flag
  // ---------------------------------------------------------------------------
  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_f_q;
  logic [DATA_W-1:0] s2_w_d, s2_w_q;
  logic [DATA_W-1:0] s2_one_hot_d, s2_one_hot_q;
  logic              s2_hit;
  logic              s2_zero_q;

  // Segment select: ascending scan keeps the highest-numbered non-empty segment.
  always_comb begin
    s2_w_d = '0;
    s2_hit = 1'b0;
    for (int s = 0; s < NSEG; s++) begin
      if (s1_any_q[s]) begin
        s2_hit = 1'b1;
        s2_w_d = DATA_W'(s * SEG_W) + DATA_W'(s1_loc_q[s]);
      end
    end
    // A zero operand must produce an all-zero mask, not bit 0.
    s2_one_hot_d = s2_hit ? (DATA_W'(1) << s2_w_d) : '0;
  end

  // S2 register: these flops drive the outputs directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q   <= 1'b0;
      s2_f_q       <= '0;
      s2_w_q       <= '0;
      s2_one_hot_q <= '0;
      s2_zero_q    <= 1'b0;
    end else if (en) begin
      s2_valid_q   <= s1_valid_q;
      s2_f_q       <= s1_f_q;
      s2_w_q       <= s2_w_d;
      s2_one_hot_q <= s2_one_hot_d;
      s2_zero_q    <= !s2_hit;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_F       = s2_f_q;
  assign out_w       = s2_w_q;
  assign out_one_hot = s2_one_hot_q;
  assign out_zero    = s2_zero_q;

endmodule

// File: tb/tb_ln_lod.sv
// Directed and randomised bench for ln_lod (DATA_W=32, SEG_W=8).
// Inputs are driven 1 time unit after the rising edge; outputs are read
// before the next edge, so every observation sees settled register values.
module tb_ln_lod;

  localparam int DATA_W = 32;
  localparam int SEG_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_F;
  logic [DATA_W-1:0] out_one_hot;
  logic [DATA_W-1:0] out_w;
  logic              out_zero;

  int checks   = 0;
  int failures = 0;

  ln_lod #(.DATA_W(DATA_W), .SEG_W(SEG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_F      (out_F),
    .out_one_hot(out_one_hot),
    .out_w      (out_w),
    .out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: index of the most significant set bit by repeated halving.
  function automatic logic [31:0] ref_msb(input logic [31:0] v);
    logic [31:0] w = 0;
    while (v > 32'd1) begin
      v = v >> 1;
      w = w + 1;
    end
    return w;
  endfunction

  function automatic logic [31:0] gen_operand();
    int k = $urandom_range(0, 9);
    if (k == 0) return 32'h0;
    if (k == 1) return 32'h1 << $urandom_range(0, 31);
    return $urandom >> $urandom_range(0, 31);
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_F !== 32'h0) begin failures++; $display("FAIL reset_out_F: got %h expected 0", out_F); end
    checks++; if (out_one_hot !== 32'h0) begin failures++; $display("FAIL reset_one_hot: got %h expected 0", out_one_hot); end
    checks++; if (out_w !== 32'h0) begin failures++; $display("FAIL reset_w: got %h expected 0", out_w); end
    checks++; if (out_zero !== 1'b0) begin failures++; $display("FAIL reset_zero: got %b expected 0", out_zero); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_discard: got out_valid=%b expected 0", out_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    in_valid = 1'b1; in_data = 32'h0001_8000; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_latency1: got out_valid=%b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_w !== 32'd16) begin failures++; $display("FAIL single_w: got %0d expected 16", out_w); end
    checks++; if (out_one_hot !== 32'h0001_0000) begin failures++; $display("FAIL single_one_hot: got %h expected 00010000", out_one_hot); end
    checks++; if (out_F !== 32'h0001_8000) begin failures++; $display("FAIL single_F: got %h expected 00018000", out_F); end
    checks++; if (out_zero !== 1'b0) begin failures++; $display("FAIL single_zero: got %b expected 0", out_zero); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_bubble: got out_valid=%b expected 0", out_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_zero();
    in_valid = 1'b1; in_data = 32'h0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL zero_valid: got %b expected 1", out_valid); end
    checks++; if (out_zero !== 1'b1) begin failures++; $display("FAIL zero_flag: got %b expected 1", out_zero); end
    checks++; if (out_w !== 32'h0) begin failures++; $display("FAIL zero_w: got %0d expected 0", out_w); end
    checks++; if (out_one_hot !== 32'h0) begin failures++; $display("FAIL zero_one_hot: got %h expected 0", out_one_hot); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Boundary operands streamed back to back: one result per cycle.
  task automatic test_boundary();
    localparam int N = 5;
    logic [31:0] vf  [N] = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0100, 32'h0000_00FF};
    logic [31:0] vw  [N] = '{32'd31,        32'd0,         32'd31,        32'd8,         32'd7};
    logic [31:0] voh [N] = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0100, 32'h0000_0080};
    out_ready = 1'b1;
    for (int c = 0; c <= N + 1; c++) begin
      in_valid = (c < N);
      in_data  = (c < N) ? vf[c] : 32'h0;
      tick();
      if (c >= 1 && c <= N) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL boundary_valid[%0d]: got %b expected 1", c-1, out_valid); end
        checks++; if (out_F !== vf[c-1]) begin failures++; $display("FAIL boundary_F[%0d]: got %h expected %h", c-1, out_F, vf[c-1]); end
        checks++; if (out_w !== vw[c-1]) begin failures++; $display("FAIL boundary_w[%0d]: got %0d expected %0d", c-1, out_w, vw[c-1]); end
        checks++; if (out_one_hot !== voh[c-1]) begin failures++; $display("FAIL boundary_one_hot[%0d]: got %h expected %h", c-1, out_one_hot, voh[c-1]); end
        checks++; if (out_zero !== 1'b0) begin failures++; $display("FAIL boundary_zero[%0d]: got %b expected 0", c-1, out_zero); end
      end
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL boundary_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  // ---------------------------------------------------------------------------
  // Stream 0x10, 0x300, 0x7000 with out_ready low during cycles 3..5.
  task automatic test_back_to_back();
    logic [31:0] ef [3] = '{32'h10, 32'h300, 32'h7000};
    logic [31:0] ew [3] = '{32'd4, 32'd9, 32'd14};
    int idx = 0, rcv = 0, stalls = 0;
    bit ix, ox;
    for (int c = 0; c < 12; c++) begin
      in_valid  = (idx < 3);
      in_data   = (idx < 3) ? ef[idx] : 32'h0;
      out_ready = !(c >= 3 && c <= 5);
      #1;
      ix = in_valid && in_ready;
      ox = out_valid && out_ready;
      if (out_valid && rcv < 3) begin
        checks++; if (out_F !== ef[rcv]) begin failures++; $display("FAIL b2b_F[c%0d]: got %h expected %h", c, out_F, ef[rcv]); end
        checks++; if (out_w !== ew[rcv]) begin failures++; $display("FAIL b2b_w[c%0d]: got %0d expected %0d", c, out_w, ew[rcv]); end
      end
      if (out_valid && !out_ready) begin
        stalls++;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_stall[c%0d]: got %b expected 0", c, in_ready); end
      end
      if (ox) rcv++;
      if (ix) idx++;
      tick();
    end
    checks++; if (rcv !== 3) begin failures++; $display("FAIL b2b_count: got %0d expected 3", rcv); end
    checks++; if (stalls !== 3) begin failures++; $display("FAIL b2b_stall_cycles: got %0d expected 3", stalls); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid); end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midstream();
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h10;  tick();
    in_data = 32'h300; tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid: got %b expected 1", out_valid); end
    rst = 1'b1; in_data = 32'h55; tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    checks++; if (out_F !== 32'h0) begin failures++; $display("FAIL rstmid_F: got %h expected 0", out_F); end
    checks++; if (out_w !== 32'h0) begin failures++; $display("FAIL rstmid_w: got %h expected 0", out_w); end
    checks++; if (out_one_hot !== 32'h0) begin failures++; $display("FAIL rstmid_one_hot: got %h expected 0", out_one_hot); end
    checks++; if (out_zero !== 1'b0) begin failures++; $display("FAIL rstmid_zero: got %b expected 0", out_zero); end
    rst = 1'b0; in_valid = 1'b0; tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after1: got out_valid=%b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after2: got out_valid=%b expected 0", out_valid); end
    in_valid = 1'b1; in_data = 32'h0400_0000; tick();
    in_valid = 1'b0; tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_next_valid: got %b expected 1", out_valid); end
    checks++; if (out_w !== 32'd26) begin failures++; $display("FAIL rstmid_next_w: got %0d expected 26", out_w); end
    checks++; if (out_one_hot !== 32'h0400_0000) begin failures++; $display("FAIL rstmid_next_one_hot: got %h expected 04000000", out_one_hot); end
    checks++; if (out_F !== 32'h0400_0000) begin failures++; $display("FAIL rstmid_next_F: got %h expected 04000000", out_F); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    localparam int NOPS = 10000;
    logic [31:0] q[$];
    logic [31:0] next_f, ef, ew, eoh;
    int sent = 0, rcv = 0, cyc = 0;
    bit ix, ox;
    next_f = gen_operand();
    while (rcv < NOPS && cyc < 90000) begin
      in_valid  = (sent < NOPS) && ($urandom_range(0, 3) != 0);
      in_data   = next_f;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (in_ready !== (out_ready || !out_valid)) begin failures++; $display("FAIL rand_in_ready[cyc%0d]: got %b expected %b", cyc, in_ready, out_ready || !out_valid); end
      ix = in_valid && in_ready;
      ox = out_valid && out_ready;
      if (ox) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rand_spurious[cyc%0d]: got output F=%h expected none", cyc, out_F);
        end else begin
          ef  = q.pop_front();
          ew  = (ef == 0) ? 32'h0 : ref_msb(ef);
          eoh = (ef == 0) ? 32'h0 : (32'h1 << ew);
          if (out_F !== ef) begin failures++; $display("FAIL rand_F[%0d]: got %h expected %h", rcv, out_F, ef); end
          checks++; if (out_w !== ew) begin failures++; $display("FAIL rand_w[%0d]: got %0d expected %0d", rcv, out_w, ew); end
          checks++; if (out_one_hot !== eoh) begin failures++; $display("FAIL rand_one_hot[%0d]: got %h expected %h", rcv, out_one_hot, eoh); end
          checks++; if (out_zero !== (ef == 0)) begin failures++; $display("FAIL rand_zero[%0d]: got %b expected %b", rcv, out_zero, ef == 0); end
          if (ef != 0) begin
            checks++; if ((out_F & out_one_hot) !== out_one_hot) begin failures++; $display("FAIL rand_ident_and[%0d]: got %h expected %h", rcv, out_F & out_one_hot, out_one_hot); end
            checks++; if (!((out_F & ~out_one_hot) < out_one_hot)) begin failures++; $display("FAIL rand_ident_lt[%0d]: got rest=%h not below %h", rcv, out_F & ~out_one_hot, out_one_hot); end
          end
        end
        rcv++;
      end
      if (ix) begin
        q.push_back(next_f);
        sent++;
        next_f = gen_operand();
      end
      tick();
      cyc++;
    end
    checks++; if (rcv != NOPS) begin failures++; $display("FAIL rand_timeout: got %0d results expected %0d", rcv, NOPS); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rand_leftover: got %0d pending expected 0", q.size()); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rand_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_single();
    test_zero();
    test_boundary();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ln_lod.md
LN_LOD -- requirements
Module: ln_lod

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width; it SHALL equal the output-buffer data size used by the ln datapath.
REQ-002 The block SHALL have parameter SEG_W, default 8, giving the segment width for the first-stage search; DATA_W SHALL be an integer multiple of SEG_W.
REQ-003 The block SHALL have the following ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  DATA_W  unsigned fixed-point operand F.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  downstream accepts the result.
- out_F  output  DATA_W  F carried through, aligned with its result.
- out_one_hot  output  DATA_W  one-hot mask of the most significant set bit of F.
- out_w  output  DATA_W  bit index of that set bit, zero-extended.
- out_zero  output  1  F was zero.

Function
REQ-004 The block SHALL be a two-stage pipeline, S1 then S2, each stage having its own valid flag.
REQ-005 A transfer SHALL occur on in_valid && in_ready; an output transfer SHALL occur on out_valid && out_ready.
REQ-006 The pipeline enable SHALL be en = out_ready || !out_valid; both stages SHALL advance only when en=1, and in_ready SHALL equal en.
REQ-007 When en=1, S1 SHALL capture:
- F;
- per segment, an any-set flag;
- per segment, the local index of its highest set bit.
S1 valid SHALL take the value of in_valid.
REQ-008 When en=1, S2 SHALL:
- select the highest-numbered segment whose any-set flag is 1;
- form w = seg_idx*SEG_W + local_idx;
- form one_hot = 1 << w;
- capture F;
- take S2 valid from S1 valid.
REQ-009 S2 registers SHALL drive the outputs directly, with no combinational path from in_data to any output.
REQ-010 Latency SHALL be 2 cycles from the input transfer to out_valid with out_ready held high, and throughput SHALL be 1 operand per cycle.
REQ-011 For F=0, the block SHALL output out_zero=1, out_w=0 and out_one_hot=0; for F≠0, out_zero SHALL be 0.
REQ-012 The identities out_F & out_one_hot == out_one_hot and (out_F & ~out_one_hot) < out_one_hot SHALL hold for every valid F≠0 result.
REQ-013 While out_valid=1 and out_ready=0, all output fields SHALL remain stable and no input SHALL be accepted.
REQ-014 When in_valid=0 with en=1, bubbles SHALL propagate, and out_valid SHALL fall after the last operand is consumed.
REQ-015 When a new input is accepted in the same cycle the output is consumed, no data SHALL be lost or duplicated.
REQ-016 Data registers SHALL be enabled only by en and SHALL hold their values otherwise, with no X propagation on bubbles.
REQ-017 Operand order SHALL be preserved.

Reset
REQ-018 On rst=1 at a clock edge, both stage valid flags SHALL clear to 0, and out_F, out_one_hot, out_w and out_zero SHALL clear to 0.
REQ-019 During rst, in_ready SHALL be 1 (out_valid=0) and any concurrent in_valid SHALL be discarded.
REQ-020 A reset asserted mid-operation SHALL drop all in-flight operands, with out_valid=0 on the first cycle after reset is released.

Verification
REQ-021 The bench SHALL cover a single operand: in_data=0x0001_8000, out_ready=1 -> 2 cycles later out_valid=1, out_w=16, out_one_hot=0x0001_0000, out_F=0x0001_8000, out_zero=0.
REQ-022 The bench SHALL cover boundary bits: 0x8000_0000 gives w=31 and one_hot=0x8000_0000; 0x0000_0001 gives w=0 and one_hot=1; 0xFFFF_FFFF gives w=31.
REQ-023 The bench SHALL cover the zero input: in_data=0 -> out_zero=1, out_w=0, out_one_hot=0.
REQ-024 The bench SHALL cover back-to-back backpressure: stream 0x10, 0x300, 0x7000 with out_ready low for cycles 3-5 -> outputs held stable, in_ready=0 while stalled, results w=4, 9, 14 delivered in order with no loss.
REQ-025 The bench SHALL cover reset mid-stream: assert rst with both stages valid -> next cycle out_valid=0 and all outputs 0, and the operand following reset produces a correct result at latency 2.
REQ-026 The bench SHALL run a random sweep of 10k operands with random in_valid and out_ready against a reference model, checking REQ-011 and REQ-012 and ordering.
